// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryptor: one forward key-expansion step or one inverse
// round per clock. The cipher key is expanded to round key 10 first, then the
// inverse key schedule walks back to round key 0 alongside the inverse rounds.
module aes_128_dec_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;
  localparam logic [7:0]  INV_EXP = 8'hfe;  // a^254 == a^-1 in GF(2^8)

  // Byte n of a block (FIPS-197 order) lives at index 15-n.
  typedef logic [15:0][7:0] blk_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] st;
  logic [BLK_W-1:0] rk;

  logic [7:0]       rc;
  logic [BLK_W-1:0] ks_fwd;
  logic [BLK_W-1:0] ks_inv;
  logic [BLK_W-1:0] rnd_ark;
  logic [BLK_W-1:0] rnd_out;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse by square-and-multiply; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (INV_EXP[3'(i)]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  // Forward S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Round constant for schedule step i (0-based).
  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] i);
    logic [7:0] r;
    case (i)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // SubWord(RotWord(w)).
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // One forward key-expansion step.
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {r, 24'h000000};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // One inverse key-schedule step: round key r -> round key r-1.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] r);
    logic [31:0] a, b, c, d;
    d = k[31:0] ^ k[63:32];
    c = k[63:32] ^ k[95:64];
    b = k[95:64] ^ k[127:96];
    a = k[127:96] ^ sub_rot_word(d) ^ {r, 24'h000000};
    return {a, b, c, d};
  endfunction

  // Row r rotates right by r columns.
  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4'(15 - (r + 4 * c))] = s[4'(15 - (r + 4 * ((c - r) & 3)))];
      end
    end
    return o;
  endfunction

  // Sixteen parallel inverse S-box lookups.
  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t o;
    o = '0;
    for (int n = 0; n < 16; n++) begin
      o[4'(n)] = inv_sbox(s[4'(n)]);
    end
    return o;
  endfunction

  // Column-wise multiply by the circulant {0e,0b,0d,09}.
  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t       o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4'(15 - 4 * c)];
      a1 = s[4'(14 - 4 * c)];
      a2 = s[4'(13 - 4 * c)];
      a3 = s[4'(12 - 4 * c)];
      o[4'(15 - 4 * c)] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[4'(14 - 4 * c)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[4'(13 - 4 * c)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[4'(12 - 4 * c)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Datapath: next round key (both directions) and one inverse round.
  always_comb begin
    rc      = rcon(cnt);
    ks_fwd  = key_fwd(rk, rc);
    ks_inv  = key_inv(rk, rc);
    rnd_ark = inv_sub_bytes(inv_shift_rows(st)) ^ ks_inv;
    rnd_out = (cnt == '0) ? rnd_ark : inv_mix_columns(rnd_ark);
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= '0;
      st        <= '0;
      rk        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st       <= state;
            rk       <= key;
            cnt      <= '0;
            in_ready <= 1'b0;
            fsm      <= KEYEXP;
          end
        end
        KEYEXP: begin
          if (cnt == 4'd10) begin
            st  <= st ^ rk;
            cnt <= 4'd9;
            fsm <= ROUND;
          end else begin
            rk  <= ks_fwd;
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          st <= rnd_out;
          rk <= ks_inv;
          if (cnt == '0) begin
            out       <= rnd_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Scoreboard bench for aes_128_dec_iter: known FIPS-197 vectors, backpressure,
// back-to-back, mid-operation reset and a randomized encrypt/decrypt round trip.
module tb_aes_128_dec_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int N_RAND = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           acc_log[$];
  int           cyc = 0;
  int           done_cnt = 0;
  bit           ov_prev = 1'b0;
  logic [127:0] held = '0;
  bit           rdy_rand = 1'b0;
  logic         rdy_force = 1'b1;

  logic [7:0]   sbox_t[256];
  logic [7:0]   exp_t[256];
  logic [7:0]   log_t[256];

  aes_128_dec_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state     (state),
    .key       (key),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: either a forced level or a random one each cycle.
  always @(posedge clk) begin
    #1 out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from log/antilog tables over generator 03 and the bitwise affine map.
  task automatic build_tables();
    logic [7:0] e;
    logic [7:0] v;
    logic [7:0] b;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = 8'(i);
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      v = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
      for (int i = 0; i < 8; i++) begin
        b[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
      end
      sbox_t[x] = b;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   rcv;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
    rcv = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rcv, 24'h0};
        rcv = xt(rcv);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = 8'(pt >> (120 - 8 * n)) ^ 8'(w[n / 4] >> (24 - 8 * (n % 4)));
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) s[n] = sbox_t[s[n]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr + 4 * c] = s[rr + 4 * ((c + rr) % 4)];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ 8'(w[4 * rnd + n / 4] >> (24 - 8 * (n % 4)));
    end
    r = '0;
    for (int n = 0; n < 16; n++) r = {r[119:0], s[n]};
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    int lat;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      if (out_valid && !ov_prev) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out_valid: got out=%h with no pending request", out);
        end else begin
          lat = cyc - acc_q.pop_front();
          check("latency", 128'(lat), 128'd21);
          check("plaintext", out, exp_q.pop_front());
        end
        held = out;
      end else if (out_valid && ov_prev) begin
        check("held_out", out, held);
        check("in_ready_in_done", 128'(in_ready), 128'd0);
      end
      if (out_valid && out_ready) done_cnt++;
    end
    ov_prev = out_valid;
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept(input string name);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i >= 200) begin
        fail_now(name);
        break;
      end
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    state    = ct;
    key      = k;
    exp_q.push_back(pt);
    wait_accept("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    state    = rnd128();
    key      = rnd128();
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (done_cnt >= target) break;
      if (i >= 500) begin
        fail_now("done_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [127:0] k;
    logic [127:0] pt;
    build_tables();
    rst      = 1'b1;
    in_valid = 1'b0;
    state    = '0;
    key      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out", out, 128'd0);

    // Known-answer vectors.
    send(C1_KEY, C1_CT, C1_PT);
    wait_done(1);
    send(B_KEY, B_CT, B_PT);
    wait_done(2);

    // Backpressure with input noise while the result is held.
    rdy_force = 1'b0;
    send(C1_KEY, C1_CT, C1_PT);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (i >= 100) begin
        fail_now("bp_out_valid_timeout");
        break;
      end
    end
    base = acc_log.size();
    repeat (6) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      state    = rnd128();
      key      = rnd128();
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    rdy_force = 1'b1;
    check("bp_no_accept", 128'(acc_log.size()), 128'(base));
    wait_done(3);
    repeat (3) begin
      @(negedge clk);
      check("out_kept_after_handshake", out, C1_PT);
    end

    // Back-to-back with in_valid held high.
    base = acc_log.size();
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    state    = C1_CT;
    key      = C1_KEY;
    exp_q.push_back(C1_PT);
    wait_accept("b2b_first_accept");
    @(posedge clk);
    #1;
    state = B_CT;
    key   = B_KEY;
    exp_q.push_back(B_PT);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (acc_log.size() >= base + 2) break;
      if (i >= 200) begin
        fail_now("b2b_second_accept");
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (acc_log.size() >= base + 2)
      check("b2b_accept_interval", 128'(acc_log[base+1] - acc_log[base]), 128'd23);
    wait_done(5);

    // Reset at acceptance edge + 15 abandons the operation.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    state    = C1_CT;
    key      = C1_KEY;
    exp_q.push_back(C1_PT);
    wait_accept("mid_rst_accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_out", out, 128'd0);
    send(B_KEY, B_CT, B_PT);
    wait_done(6);

    // Randomized round trip through the reference encryptor.
    rdy_rand = 1'b1;
    base = done_cnt;
    for (int i = 0; i < N_RAND; i++) begin
      k  = rnd128();
      pt = rnd128();
      send(k, aes_enc(k, pt), pt);
    end
    wait_done(base + N_RAND);
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
